// File: rtl/sync_updown_counter_if.sv
// sync_updown_counter_if: count-control and count-output bundle for the up/down counter
interface sync_updown_counter_if #(parameter int WIDTH = 3);
  logic t;
  logic M;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] qb;
  logic tc;
  modport master (output t, M, input q, qb, tc);
  modport slave (input t, M, output q, qb, tc);
endinterface

// File: rtl/sync_updown_counter.sv
// sync_updown_counter: synchronous up/down counter built from a chain of toggle stages
module sync_updown_counter #(parameter int WIDTH = 3) (
  input logic clk,
  input logic res,
  sync_updown_counter_if.slave bus
);
  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] tog;
  // a stage toggles only when every lower stage sits at its terminal value for the direction
  assign tog[0] = bus.t;
  for (genvar g = 1; g < WIDTH; g++) begin : g_stage
    assign tog[g] = tog[g-1] & (bus.M ? ~cnt[g-1] : cnt[g-1]);
  end
  always_ff @(posedge clk)
    if (res) cnt <= '0;
    else cnt <= cnt ^ tog;
  assign bus.q = cnt;
  assign bus.qb = ~cnt;
  assign bus.tc = bus.t & (bus.M ? (cnt == '0) : (&cnt));
endmodule

// File: tb/tb_sync_updown_counter.sv
// tb_sync_updown_counter: directed vectors with an arithmetic reference model checked every cycle
module tb_sync_updown_counter;
  localparam int W = 3;
  logic clk = 0;
  logic res = 0;
  int total = 0;
  int bad = 0;
  logic [W-1:0] mq;
  bit valid = 0;
  sync_updown_counter_if #(.WIDTH(W)) bus();
  sync_updown_counter #(.WIDTH(W)) dut (.clk(clk), .res(res), .bus(bus.slave));
  always #5 clk = ~clk;
  always @(posedge clk)
    if (res) begin
      mq = '0;
      valid = 1;
    end else if (valid && bus.t) mq = bus.M ? mq - 1'b1 : mq + 1'b1;
  always @(negedge clk)
    if (valid) begin
      total++;
      if (bus.q !== mq || bus.qb !== ~mq ||
          bus.tc !== (bus.t && (bus.M ? (mq == 0) : (mq == {W{1'b1}})))) begin
        bad++;
        $display("FAIL model t=%b M=%b q=%b qb=%b tc=%b expected q=%b", bus.t, bus.M, bus.q, bus.qb, bus.tc, mq);
      end
    end
  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%b expected=%b", name, act, exp);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  initial begin
    logic [W-1:0] upv [9] = '{1, 2, 3, 4, 5, 6, 7, 0, 1};
    logic [W-1:0] dnv [9] = '{7, 6, 5, 4, 3, 2, 1, 0, 7};
    bus.t = 1;
    bus.M = 0;
    res = 1;
    tick(2);
    chk("reset_q", bus.q, 3'b000);
    chk("reset_qb", bus.qb, 3'b111);
    res = 0;
    bus.t = 0;
    tick(4);
    chk("hold_q", bus.q, 3'b000);
    chk("hold_tc", {2'b0, bus.tc}, 3'b000);
    bus.t = 1;
    for (int i = 0; i < 9; i++) begin
      tick(1);
      chk("up_q", bus.q, upv[i]);
      chk("up_tc", {2'b0, bus.tc}, {2'b0, upv[i] == 3'b111});
    end
    res = 1;
    tick(1);
    res = 0;
    bus.M = 1;
    #1;
    chk("down_tc_after_reset", {2'b0, bus.tc}, 3'b001);
    for (int i = 0; i < 9; i++) begin
      tick(1);
      chk("down_q", bus.q, dnv[i]);
      chk("down_tc", {2'b0, bus.tc}, {2'b0, dnv[i] == 3'b000});
    end
    res = 1;
    tick(1);
    res = 0;
    bus.M = 0;
    tick(3);
    chk("dir_up_to3", bus.q, 3'b011);
    bus.M = 1;
    tick(1);
    chk("dir_down_a", bus.q, 3'b010);
    tick(1);
    chk("dir_down_b", bus.q, 3'b001);
    bus.M = 0;
    tick(1);
    chk("dir_back_up", bus.q, 3'b010);
    tick(1);
    chk("gate_start", bus.q, 3'b011);
    bus.t = 0;
    tick(3);
    chk("gate_hold_q", bus.q, 3'b011);
    chk("gate_hold_tc", {2'b0, bus.tc}, 3'b000);
    bus.t = 1;
    tick(1);
    chk("gate_resume", bus.q, 3'b100);
    tick(1);
    chk("mid_pre", bus.q, 3'b101);
    res = 1;
    tick(1);
    chk("mid_reset_q", bus.q, 3'b000);
    chk("mid_reset_qb", bus.qb, 3'b111);
    res = 0;
    tick(1);
    chk("mid_resume", bus.q, 3'b001);
    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/sync_updown_counter.md
Name: sync_updown_counter

Overview:
- Synchronous binary up/down counter, default 3 bits wide.
- Built as a chain of toggle stages: stage i toggles when the global count enable is high and all lower stages are at their terminal value for the selected direction.
- Provides true and complemented count outputs plus a terminal-count flag, for use as a small sequencer or divider in the counter library.

Parameters:
- WIDTH, 3, number of counter bits (must be ≥1).

Ports:
- clk, input, 1, single clock; all state updates on the rising edge.
- res, input, 1, synchronous active-high reset; sampled on the rising edge of clk.
- t, input, 1, count enable; 1 = advance one step per clock, 0 = hold.
- M, input, 1, direction; 0 = count up, 1 = count down.
- q, output, WIDTH, current count value (registered).
- qb, output, WIDTH, bitwise complement of q; always equal to ~q, including during and after reset.
- tc, output, 1, terminal count, combinational:
  - 1 when t=1, M=0 and q = all ones;
  - 1 when t=1, M=1 and q = 0;
  - 0 otherwise.

Behaviour:
- Reset:
  - On a rising clk edge with res=1: q becomes 0 and qb becomes all ones.
  - Reset takes priority over t and M.
  - Reset asserted mid-count clears the counter at the next edge; no asynchronous effect.
  - tc follows its combinational equation on the reset value (e.g. t=1, M=1 after reset gives tc=1).
- Count, on a rising edge with res=0:
  - t=0: q holds, whatever M is. No bit toggles; t gates every stage, not just bit 0.
  - t=1, M=0: q ← (q+1) mod 2^WIDTH.
  - t=1, M=1: q ← (q−1) mod 2^WIDTH.
- Toggle-stage formulation (equivalent to the above):
  - T0 = t.
  - Ti = t AND (M ? all q[i−1:0]==0 : all q[i−1:0]==1).
  - Each q[i] ← q[i] XOR Ti.
- Wrap-around:
  - Up from 2^WIDTH−1 goes to 0.
  - Down from 0 goes to 2^WIDTH−1.
  - Both produce tc=1 in the cycle before the wrap.
- Direction change: M is sampled on each edge; a change takes effect on the very next edge with no extra latency and no lost or duplicated step.
- Latency: one clock from sampled inputs to the q update; tc has zero latency from t, M and q.
- No X propagation: all outputs are defined from the first reset edge onward.
- Outputs before the first reset are unspecified; a bench must apply reset first.

Test Plan:
- Reset, then hold: res=1 for 2 edges with t=1 → q=000, qb=111. Then res=0, t=0 for 4 edges → q stays 000.
- Up count with wrap: res=0, t=1, M=0 from q=000 for 9 edges → q = 001,010,…,111,000,001. tc=1 only while q=111.
- Down count with wrap: reset, then M=1, t=1 for 9 edges → q = 111,110,…,000,111. tc=1 while q=000 (including immediately after reset).
- Direction switch: up from 000 to q=011, then set M=1 → next edges give 010,001. Switch back to M=0 → next edge gives 010.
- Enable gating: at q=011 with M=0, drop t for 3 edges → q stays 011 and tc=0. Raise t → 100.
- Mid-count reset: counting up at q=101, assert res=1 for one edge → q=000, qb=111 on that edge. Deassert → counting resumes from 000 (next value 001 if M=0).
